quadrature_decoder: RTL and testbench

//  Receives quadrature A/B from an external encoder or an encoder emulator and decodes every edge (x4).

---
 rtl/qdec_pkg.sv | 17 +
 rtl/qdec_glitch_filter.sv | 44 ++++
 rtl/quadrature_decoder.sv | 165 ++++++++++++++++
 tb/tb_quadrature_decoder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// rtl/qdec_pkg.sv - register map, FSM state types and STATUS bit layout for the quadrature decoder
package qdec_pkg;

  localparam logic [7:0] ADDR_POSITION   = 8'h00;
  localparam logic [7:0] ADDR_ERR_COUNT  = 8'h08;
  localparam logic [7:0] ADDR_FILTER_LEN = 8'h10;
  localparam logic [7:0] ADDR_STATUS     = 8'h18;

  localparam int STAT_STICKY = 0;
  localparam int STAT_DIR    = 1;
  localparam int STAT_A      = 2;
  localparam int STAT_B      = 3;

  typedef enum logic {R_IDLE, R_VALID} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

endpackage

// File: rtl/qdec_glitch_filter.sv
// rtl/qdec_glitch_filter.sv - per-channel synchroniser plus stability-count glitch filter
module qdec_glitch_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din,
  input  logic [15:0] filt_len,
  input  logic        filt_restart,
  output logic        dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [15:0]            cnt_q;
  logic                   filt_q;
  logic                   synced;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Count cycles the synced level differs from the accepted one; accept on the filt_len-th.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q <= synced;
      cnt_q  <= '0;
    end else if (filt_restart) begin
      cnt_q  <= '0;
    end else if (filt_len == 16'd0 || synced == filt_q) begin
      filt_q <= synced;
      cnt_q  <= '0;
    end else if (cnt_q == filt_len - 16'd1) begin
      filt_q <= synced;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 16'd1;
    end
  end

  assign dout = (filt_len == 16'd0) ? synced : filt_q;

endmodule

// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - x4 quadrature decoder with position/error counters and AXI-Lite register port
module quadrature_decoder
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_RST_VAL = 4,
  parameter int ERR_CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        encoder_a,
  input  logic        encoder_b,
  output logic [63:0] position,
  output logic        direction,
  output logic        step,
  output logic        error,
  input  logic        cp_awvalid,
  output logic        cp_awready,
  input  logic [7:0]  cp_awaddr,
  input  logic        cp_wvalid,
  output logic        cp_wready,
  input  logic [63:0] cp_wdata,
  output logic        cp_bvalid,
  input  logic        cp_bready,
  output logic [1:0]  cp_bresp,
  input  logic        cp_arvalid,
  output logic        cp_arready,
  input  logic [7:0]  cp_araddr,
  output logic        cp_rvalid,
  input  logic        cp_rready,
  output logic [63:0] cp_rdata,
  output logic [1:0]  cp_rresp
);

  logic                 a_f, b_f, prev_a, prev_b, armed_q;
  logic [63:0]          pos_q, rd_mux, rdata_q;
  logic                 dir_q, step_q, err_q, sticky_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [15:0]          filt_len_q;
  logic [7:0]           awaddr_q;
  rd_state_t            rd_state, rd_next;
  wr_state_t            wr_state, wr_next;
  logic                 wr_en, wr_pos, wr_err, wr_flt, wr_stat;
  logic                 a_chg, b_chg, fwd, rev, illegal;
  logic                 unused_wdata;

  assign unused_wdata = ^cp_wdata[63:16];

  assign wr_en   = (wr_state == W_DATA) && cp_wvalid;
  assign wr_pos  = wr_en && (awaddr_q == ADDR_POSITION);
  assign wr_err  = wr_en && (awaddr_q == ADDR_ERR_COUNT);
  assign wr_flt  = wr_en && (awaddr_q == ADDR_FILTER_LEN);
  assign wr_stat = wr_en && (awaddr_q == ADDR_STATUS);

  qdec_glitch_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filt_a (
    .clk(clk), .reset_n(reset_n), .din(encoder_a),
    .filt_len(filt_len_q), .filt_restart(wr_flt), .dout(a_f)
  );

  qdec_glitch_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filt_b (
    .clk(clk), .reset_n(reset_n), .din(encoder_b),
    .filt_len(filt_len_q), .filt_restart(wr_flt), .dout(b_f)
  );

  // Forward moves: A takes the inverse of old B, or B takes the value of old A.
  assign a_chg   = a_f ^ prev_a;
  assign b_chg   = b_f ^ prev_b;
  assign fwd     = armed_q && ((a_chg && !b_chg && (a_f != prev_b)) ||
                               (b_chg && !a_chg && (b_f == prev_a)));
  assign rev     = armed_q && (a_chg ^ b_chg) && !fwd;
  assign illegal = armed_q && a_chg && b_chg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_a     <= a_f;
      prev_b     <= b_f;
      armed_q    <= 1'b0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      sticky_q   <= 1'b0;
      filt_len_q <= 16'(FILT_RST_VAL);
    end else begin
      prev_a  <= a_f;
      prev_b  <= b_f;
      armed_q <= 1'b1;
      step_q  <= fwd || rev;
      err_q   <= illegal;
      if (fwd || rev) dir_q <= rev;
      if (wr_pos)      pos_q <= '0;
      else if (fwd)    pos_q <= pos_q + 64'd1;
      else if (rev)    pos_q <= pos_q - 64'd1;
      if (wr_err)                      err_cnt_q <= '0;
      else if (illegal && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
      if (wr_stat && cp_wdata[STAT_STICKY]) sticky_q <= 1'b0;
      else if (illegal)                     sticky_q <= 1'b1;
      if (wr_flt) filt_len_q <= cp_wdata[15:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (cp_araddr)
      ADDR_POSITION:   rd_mux = pos_q;
      ADDR_ERR_COUNT:  rd_mux = 64'(err_cnt_q);
      ADDR_FILTER_LEN: rd_mux = 64'(filt_len_q);
      ADDR_STATUS: begin
        rd_mux[STAT_STICKY] = sticky_q;
        rd_mux[STAT_DIR]    = dir_q;
        rd_mux[STAT_A]      = a_f;
        rd_mux[STAT_B]      = b_f;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      rdata_q  <= '0;
      awaddr_q <= '0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (rd_state == R_IDLE && cp_arvalid) rdata_q  <= rd_mux;
      if (wr_state == W_IDLE && cp_awvalid) awaddr_q <= cp_awaddr;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (cp_arvalid) rd_next = R_VALID;
      R_VALID: if (cp_rready)  rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (cp_awvalid) wr_next = W_DATA;
      W_DATA:  if (cp_wvalid)  wr_next = W_RESP;
      W_RESP:  if (cp_bready)  wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  assign position   = pos_q;
  assign direction  = dir_q;
  assign step       = step_q;
  assign error      = err_q;
  assign cp_awready = 1'b1;
  assign cp_arready = 1'b1;
  assign cp_wready  = (wr_state == W_DATA);
  assign cp_bvalid  = (wr_state == W_RESP);
  assign cp_rvalid  = (rd_state == R_VALID);
  assign cp_rdata   = rdata_q;
  assign cp_bresp   = 2'b00;
  assign cp_rresp   = 2'b00;

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - directed bench for quadrature_decoder with an event-queue reference model
module tb_quadrature_decoder;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n, encoder_a, encoder_b;
  logic [63:0] position;
  logic        direction, step, error;
  logic        cp_awvalid, cp_awready, cp_wvalid, cp_wready, cp_bvalid, cp_bready;
  logic        cp_arvalid, cp_arready, cp_rvalid, cp_rready;
  logic [7:0]  cp_awaddr, cp_araddr;
  logic [63:0] cp_wdata, cp_rdata;
  logic [1:0]  cp_bresp, cp_rresp;

  always #5 clk = ~clk;

  quadrature_decoder dut (
    .clk(clk), .reset_n(reset_n), .encoder_a(encoder_a), .encoder_b(encoder_b),
    .position(position), .direction(direction), .step(step), .error(error),
    .cp_awvalid(cp_awvalid), .cp_awready(cp_awready), .cp_awaddr(cp_awaddr),
    .cp_wvalid(cp_wvalid), .cp_wready(cp_wready), .cp_wdata(cp_wdata),
    .cp_bvalid(cp_bvalid), .cp_bready(cp_bready), .cp_bresp(cp_bresp),
    .cp_arvalid(cp_arvalid), .cp_arready(cp_arready), .cp_araddr(cp_araddr),
    .cp_rvalid(cp_rvalid), .cp_rready(cp_rready), .cp_rdata(cp_rdata), .cp_rresp(cp_rresp)
  );

  typedef struct { int due; int kind; } ev_t;   // kind: 1 fwd, -1 rev, 2 illegal
  ev_t         evq[$];
  ev_t         cur_ev;
  int          cyc = 0;
  int          vectors = 0, miscompares = 0;
  logic [63:0] m_pos;
  logic        m_dir, m_sticky, es, ee;
  int          m_errs, m_flen;
  logic [1:0]  m_lvl;
  int          clr_pos_cyc = -1, clr_err_cyc = -1, clr_sticky_cyc = -1;
  bit          chk_en = 0;
  int          step_cnt = 0, err_pulse_cnt = 0, last_step_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Position of a {B,A} level along the forward Gray cycle.
  function automatic int phase(logic [1:0] ba);
    case (ba)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_pins(logic [1:0] ba, int hold);
    int d;
    ev_t e;
    encoder_b = ba[1];
    encoder_a = ba[0];
    if (hold >= m_flen && ba != m_lvl) begin
      d = (phase(ba) - phase(m_lvl) + 4) % 4;
      e.due  = cyc + S + m_flen + 1;
      e.kind = (d == 1) ? 1 : (d == 3) ? -1 : 2;
      evq.push_back(e);
      m_lvl = ba;
    end
    repeat (hold) tick();
  endtask

  task automatic drain();
    repeat (12) tick();
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      es = 1'b0;
      ee = 1'b0;
      if (evq.size() > 0 && evq[0].due == cyc) begin
        cur_ev = evq.pop_front();
        if (cur_ev.kind == 2) begin
          ee = 1'b1; m_errs++; m_sticky = 1'b1;
        end else begin
          es = 1'b1; m_pos = m_pos + 64'(signed'(cur_ev.kind)); m_dir = (cur_ev.kind < 0);
        end
      end
      if (clr_pos_cyc == cyc)    m_pos = '0;
      if (clr_err_cyc == cyc)    m_errs = 0;
      if (clr_sticky_cyc == cyc) m_sticky = 1'b0;
      check("step", step, es);
      check("error", error, ee);
      check("position", position, m_pos);
      check("direction", direction, m_dir);
      if (step) begin step_cnt++; last_step_cyc = cyc; end
      if (error) err_pulse_cnt++;
    end
  end

  task automatic axi_write(logic [7:0] addr, logic [63:0] data);
    int t;
    cp_awaddr = addr; cp_awvalid = 1'b1;
    tick();
    cp_awvalid = 1'b0; cp_wdata = data; cp_wvalid = 1'b1;
    case (addr)
      8'h00: clr_pos_cyc = cyc + 1;
      8'h08: clr_err_cyc = cyc + 1;
      8'h10: m_flen = int'(data[15:0]);
      8'h18: if (data[0]) clr_sticky_cyc = cyc + 1;
      default: ;
    endcase
    tick();
    cp_wvalid = 1'b0;
    t = 0;
    while (!cp_bvalid && t < 10) begin tick(); t++; end
    check("bvalid", cp_bvalid, 1);
    check("bresp", cp_bresp, 0);
    cp_bready = 1'b1;
    tick();
    cp_bready = 1'b0;
  endtask

  task automatic axi_read(logic [7:0] addr, output logic [63:0] data, input int hold);
    int t;
    cp_araddr = addr; cp_arvalid = 1'b1;
    tick();
    cp_arvalid = 1'b0;
    t = 0;
    while (!cp_rvalid && t < 10) begin tick(); t++; end
    check("rvalid", cp_rvalid, 1);
    check("rresp", cp_rresp, 0);
    data = cp_rdata;
    repeat (hold) begin
      tick();
      check("rdata_hold", cp_rdata, data);
      check("rvalid_hold", cp_rvalid, 1);
    end
    cp_rready = 1'b1;
    tick();
    cp_rready = 1'b0;
    check("rvalid_drop", cp_rvalid, 0);
  endtask

  task automatic read_expect(logic [7:0] addr, logic [63:0] exp, string name);
    logic [63:0] d;
    axi_read(addr, d, 0);
    check(name, d, exp);
  endtask

  task automatic emulate(int end_value, int divider, bit rev_dir);
    logic [1:0] seq [4];
    int p;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    p = phase(m_lvl);
    for (int i = 0; i < end_value; i++) begin
      p = rev_dir ? (p + 3) % 4 : (p + 1) % 4;
      set_pins(seq[p], divider);
    end
  endtask

  initial begin
    int k, sc;
    logic [63:0] d;
    logic [1:0] fwd_seq [8];
    logic [1:0] rev_seq [4];
    fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    reset_n = 1'b0; encoder_a = 1'b0; encoder_b = 1'b0;
    cp_awvalid = 0; cp_awaddr = 0; cp_wvalid = 0; cp_wdata = 0; cp_bready = 0;
    cp_arvalid = 0; cp_araddr = 0; cp_rready = 0;
    m_pos = '0; m_dir = 0; m_sticky = 0; m_errs = 0; m_flen = 4; m_lvl = 2'b00;
    repeat (5) tick();
    check("rst_position", position, 0);
    check("rst_step", step, 0);
    check("rst_error", error, 0);
    check("rst_rvalid", cp_rvalid, 0);
    check("rst_wready", cp_wready, 0);
    check("rst_bvalid", cp_bvalid, 0);
    reset_n = 1'b1;
    chk_en = 1;
    read_expect(8'h10, 64'd4, "filter_len_reset");
    read_expect(8'h18, 64'd0, "status_reset");
    read_expect(8'h40, 64'd0, "unmapped_read");

    // forward steps, filter bypassed
    axi_write(8'h10, 64'd0);
    read_expect(8'h10, 64'd0, "filter_len_rw");
    sc = step_cnt;
    foreach (fwd_seq[i]) set_pins(fwd_seq[i], 2);
    drain();
    check("t1_step_pulses", step_cnt - sc, 8);
    read_expect(8'h00, 64'd8, "t1_position");
    read_expect(8'h08, 64'd0, "t1_err_count");

    // reverse steps across zero
    for (int r = 0; r < 3; r++) foreach (rev_seq[i]) set_pins(rev_seq[i], 2);
    drain();
    read_expect(8'h00, 64'hFFFF_FFFF_FFFF_FFFC, "t2_position");
    read_expect(8'h18, 64'h2, "t2_status");

    // illegal jumps
    set_pins(2'b11, 3);
    set_pins(2'b00, 3);
    drain();
    check("t3_err_pulses", err_pulse_cnt, 2);
    read_expect(8'h08, 64'd2, "t3_err_count");
    read_expect(8'h00, 64'hFFFF_FFFF_FFFF_FFFC, "t3_position");
    read_expect(8'h18, 64'h3, "t3_status_sticky");
    axi_write(8'h18, 64'h1);
    read_expect(8'h18, 64'h2, "t3_status_cleared");
    axi_write(8'h50, 64'hFF);

    // glitch filter at length 4
    axi_write(8'h10, 64'd4);
    sc = step_cnt;
    set_pins(2'b01, 3);
    set_pins(2'b00, 12);
    check("t4_glitch_nostep", step_cnt - sc, 0);
    k = cyc;
    set_pins(2'b01, 6);
    drain();
    check("t4_one_step", step_cnt - sc, 1);
    check("t4_latency", last_step_cyc - k, S + 5);
    read_expect(8'h00, 64'hFFFF_FFFF_FFFF_FFFD, "t4_position");
    set_pins(2'b00, 12);

    // emulator loop
    axi_write(8'h00, 64'd0);
    axi_write(8'h08, 64'd0);
    sc = err_pulse_cnt;
    emulate(100, 10, 1'b0);
    drain();
    read_expect(8'h00, 64'd100, "t5_position_fwd");
    emulate(100, 10, 1'b1);
    drain();
    read_expect(8'h00, 64'd0, "t5_position_rev");
    read_expect(8'h08, 64'd0, "t5_err_count");
    check("t5_no_err_pulses", err_pulse_cnt - sc, 0);

    // clear write colliding with a step
    axi_write(8'h10, 64'd0);
    read_expect(8'h00, 64'd0, "t6_pre");
    set_pins(2'b01, 1);
    axi_write(8'h00, 64'd0);
    drain();
    read_expect(8'h00, 64'd0, "t6_clear_beats_step");
    set_pins(2'b11, 2);
    drain();
    axi_read(8'h00, d, 5);
    check("t6_held_rdata", d, 64'd1);
    set_pins(2'b01, 3);
    set_pins(2'b00, 3);
    drain();
    check("t6_pre_reset_dir", direction, 1);

    // reset in the middle of both transactions
    cp_awaddr = 8'h10; cp_awvalid = 1'b1; cp_araddr = 8'h00; cp_arvalid = 1'b1;
    tick();
    cp_awvalid = 1'b0; cp_arvalid = 1'b0;
    check("t6_wready_pre", cp_wready, 1);
    check("t6_rvalid_pre", cp_rvalid, 1);
    chk_en = 0;
    reset_n = 1'b0;
    tick();
    check("t6_rst_position", position, 0);
    check("t6_rst_direction", direction, 0);
    check("t6_rst_step", step, 0);
    check("t6_rst_error", error, 0);
    check("t6_rst_rvalid", cp_rvalid, 0);
    check("t6_rst_wready", cp_wready, 0);
    check("t6_rst_bvalid", cp_bvalid, 0);
    check("t6_arready", cp_arready, 1);
    check("t6_awready", cp_awready, 1);
    reset_n = 1'b1;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
